// File: rtl/sample_player.sv
`default_nettype none
// ============================================================================
// sample_player : ROM playback sequencer with sample-rate divider and PWM out.
// Optional SAMPLE_PLAYER_LOOP_EN adds a loop input.   Revision: 1.0
// ============================================================================
module sample_player #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 16,
   parameter int DIV   = 3375
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [ADDR-1:0]  seg_base,
   input  logic [ADDR-1:0]  seg_len,
`ifdef SAMPLE_PLAYER_LOOP_EN
   input  logic             loop,
`endif
   output logic             busy,
   output logic             done,
   output logic [ADDR-1:0]  rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid,
   output logic             pwm_out
);

   localparam int              CNT_W    = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WAIT} state_t;

   state_t           state_q, state_d;
   logic [ADDR-1:0]  base_q, base_d;
   logic [ADDR-1:0]  len_q, len_d;
   logic [ADDR-1:0]  idx_q, idx_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
   logic             pwm_q, pwm_d;
   logic             loop_en;
   logic [WIDTH-1:0] level;

`ifdef SAMPLE_PLAYER_LOOP_EN
   assign loop_en = loop;
`else
   assign loop_en = 1'b0;
`endif

   // Offset-binary view of the signed sample: 0 maps to mid-scale duty.
   assign level = {~sample_q[WIDTH-1], sample_q[WIDTH-2:0]};

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q + 1'b1;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      pwm_d     = (pwm_cnt_q < level);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start && !stop) begin
               if (seg_len != '0) begin
                  base_d  = seg_base;
                  len_d   = seg_len;
                  addr_d  = seg_base;
                  idx_d   = '0;
                  busy_d  = 1'b1;
                  state_d = FETCH;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         FETCH: state_d = CAPTURE;
         CAPTURE: begin
            sample_d = rom_data;
            valid_d  = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (idx_q == len_q - 1'b1) begin
                  if (loop_en) begin
                     addr_d  = base_q;
                     idx_d   = '0;
                     state_d = FETCH;
                  end else begin
                     done_d   = 1'b1;
                     busy_d   = 1'b0;
                     sample_d = '0;
                     state_d  = IDLE;
                  end
               end else begin
                  addr_d  = addr_q + 1'b1;
                  idx_d   = idx_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything, including a capture in flight.
      if (stop && state_q != IDLE) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         sample_d = '0;
         valid_d  = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         pwm_cnt_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= pwm_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign rom_addr     = addr_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign pwm_out      = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_player.sv
`default_nettype none
// ============================================================================
// tb_sample_player : randomized scoreboard bench for sample_player.
// Revision: 1.0
// ============================================================================
module tb_sample_player;

   localparam int DIV  = 8;
   localparam int DIV2 = 600;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0;
   logic [15:0] seg_base = '0, seg_len = '0;
   logic        busy, done, sample_valid, pwm_out;
   logic [15:0] rom_addr;
   logic [7:0]  rom_q, sample;

   logic        start2 = 1'b0;
   logic [15:0] seg_base2 = 16'h0020, seg_len2 = 16'd2;
   logic        busy2, done2, sample_valid2, pwm2;
   logic [15:0] rom_addr2;
   logic [7:0]  rom_q2, sample2;
`ifdef SAMPLE_PLAYER_LOOP_EN
   logic        loop = 1'b0;
   logic        loop2 = 1'b0;
`endif

   logic [7:0] rom [0:65535];

   typedef struct {
      int          cyc;
      logic [7:0]  val;
      logic [15:0] addr;
   } sv_ev_t;

   sv_ev_t sv_exp[$];
   int     done_exp[$];
   int     cyc = 0;
   int     busy_from = 0, idle_from = 0;
   int     n_chk = 0, n_pass = 0;
   bit     mon_en = 1'b0;

   sample_player #(.WIDTH(8), .ADDR(16), .DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .seg_base(seg_base), .seg_len(seg_len),
`ifdef SAMPLE_PLAYER_LOOP_EN
      .loop(loop),
`endif
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_q),
      .sample(sample), .sample_valid(sample_valid), .pwm_out(pwm_out)
   );

   sample_player #(.WIDTH(8), .ADDR(16), .DIV(DIV2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stop(1'b0),
      .seg_base(seg_base2), .seg_len(seg_len2),
`ifdef SAMPLE_PLAYER_LOOP_EN
      .loop(loop2),
`endif
      .busy(busy2), .done(done2), .rom_addr(rom_addr2), .rom_data(rom_q2),
      .sample(sample2), .sample_valid(sample_valid2), .pwm_out(pwm2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM with one clock of read latency.
   always @(posedge clk) begin
      rom_q  <= rom[rom_addr];
      rom_q2 <= rom[rom_addr2];
   end

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic cancel_after(input int c);
      while (sv_exp.size() > 0 && sv_exp[$].cyc > c) void'(sv_exp.pop_back());
      while (done_exp.size() > 0 && done_exp[$] > c) void'(done_exp.pop_back());
   endtask

   // Reference model: a segment accepted in cycle c fetches sample k at
   // c+1+DIV*k, shows it 2 cycles later and finishes at c+1+len*reps*DIV.
   task automatic model(input int c, input bit st, input bit sp, input bit rs,
                        input logic [15:0] b, input logic [15:0] l, input int reps);
      bit active;
      int t0;
      logic [15:0] a;
      active = (c >= busy_from) && (c < idle_from);
      if (sp || rs) begin
         cancel_after(c);
         if (active) idle_from = c + 1;
      end else if (st && !active) begin
         if (l == 16'd0) begin
            done_exp.push_back(c + 1);
         end else begin
            t0 = c + 1;
            for (int k = 0; k < int'(l) * reps; k++) begin
               a = b + 16'(k % int'(l));
               sv_exp.push_back('{cyc: t0 + DIV * k + 2, val: rom[a], addr: a});
            end
            busy_from = t0;
            idle_from = t0 + int'(l) * reps * DIV;
            done_exp.push_back(idle_from);
         end
      end
   endtask

   task automatic drive(input bit st, input bit sp, input bit rs,
                        input logic [15:0] b, input logic [15:0] l, input int reps);
      start = st; stop = sp; rst = rs; seg_base = b; seg_len = l;
      model(cyc, st, sp, rs, b, l, reps);
      tick();
      start = 1'b0; stop = 1'b0; rst = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      bit     exp_busy, exp_sv, exp_done;
      sv_ev_t e;
      if (mon_en) begin
         exp_busy = (cyc >= busy_from) && (cyc < idle_from);
         chk(busy === exp_busy, "busy", busy, exp_busy);
         if (!exp_busy) chk(sample === 8'h00, "idle_sample", sample, 0);
         exp_sv = (sv_exp.size() > 0) && (sv_exp[0].cyc == cyc);
         if (exp_sv || sample_valid !== 1'b0) begin
            chk(sample_valid === exp_sv, "sample_valid", sample_valid, exp_sv);
            if (exp_sv) begin
               e = sv_exp.pop_front();
               chk(sample === e.val, "sample", sample, e.val);
               chk(rom_addr === e.addr, "rom_addr", rom_addr, e.addr);
            end
         end
         exp_done = (done_exp.size() > 0) && (done_exp[0] == cyc);
         if (exp_done || done !== 1'b0) begin
            chk(done === exp_done, "done", done, exp_done);
            if (exp_done) void'(done_exp.pop_front());
         end
      end
   end

   initial begin
      int c, t0, cnt, r;
      for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
      rom[16'h0010] = 8'h05; rom[16'h0011] = 8'h80; rom[16'h0012] = 8'h7F;
      rom[16'h0020] = 8'h80; rom[16'h0021] = 8'h7F;

      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      mon_en = 1'b1;

      // Reference segment: 5, -128, 127 then done at 3*DIV.
      drive(1, 0, 0, 16'h0010, 16'd3, 1);
      wait_until(idle_from + 4);
      // Zero-length request.
      drive(1, 0, 0, 16'h1234, 16'd0, 1);
      wait_until(cyc + 4);
      // Address wrap.
      drive(1, 0, 0, 16'hFFFE, 16'd4, 1);
      wait_until(idle_from + 4);
      // Start ignored mid-play, then stop during the second capture.
      c = cyc;
      drive(1, 0, 0, 16'h0100, 16'd5, 1);
      t0 = c + 1;
      wait_until(t0 + 5);
      drive(1, 0, 0, 16'h0200, 16'd2, 1);
      wait_until(t0 + 9);
      drive(0, 1, 0, 16'h0000, 16'd0, 1);
      wait_until(t0 + 50);
      // Start and stop together in IDLE.
      drive(1, 1, 0, 16'h0300, 16'd2, 1);
      wait_until(cyc + 20);

`ifdef SAMPLE_PLAYER_LOOP_EN
      loop = 1'b1;
      c = cyc;
      drive(1, 0, 0, 16'h0040, 16'd2, 2);
      wait_until(c + 1 + 20);
      loop = 1'b0;
      wait_until(idle_from + 4);
`endif

      // PWM at mid-scale while idle.
      cnt = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         cnt += int'(pwm_out);
      end
      chk(cnt == 256, "pwm_zero_duty", cnt, 256);

      // PWM at both extremes using the slow instance.
      start2 = 1'b1;
      c = cyc;
      tick();
      start2 = 1'b0;
      t0 = c + 1;
      wait_until(t0 + 10);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         cnt += int'(pwm2);
      end
      chk(cnt == 0, "pwm_min_duty", cnt, 0);
      wait_until(t0 + DIV2 + 10);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         cnt += int'(pwm2);
      end
      chk(cnt == 255, "pwm_max_duty", cnt, 255);
      wait_until(t0 + 2 * DIV2 + 4);

      // Randomized segments with stray starts, stops and resets.
      for (int trial = 0; trial < 60; trial++) begin
         repeat ($urandom_range(0, 3)) tick();
         drive(1, ($urandom_range(0, 9) == 0), 0, 16'($urandom), 16'($urandom_range(0, 5)), 1);
         for (int n = 0; n < 60 && cyc < idle_from + 2; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       drive(0, 1, 0, 16'h0, 16'h0, 1);
            else if (r < 4)  drive(0, 0, 1, 16'h0, 16'h0, 1);
            else if (r < 10) drive(1, 0, 0, 16'($urandom), 16'($urandom_range(0, 5)), 1);
            else             tick();
         end
         tick();
      end
      wait_until(cyc + 4);

      chk(sv_exp.size() == 0, "leftover_sample_valid", sv_exp.size(), 0);
      chk(done_exp.size() == 0, "leftover_done", done_exp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sample_player.md
Name: sample_player

Overview:
- Playback sequencer that sits directly upstream of the sample ROM.
- Steps a ROM read address through a requested segment (base, length) at a fixed sample rate set by a clock divider.
- Captures the signed ROM output one cycle after each address and presents it as a registered sample with a valid strobe.
- Also drives a PWM audio pin from the current sample.

Parameters:
- WIDTH, 8, sample width in bits; must match the ROM data width.
- ADDR, 16, ROM address width in bits.
- DIV, 3375, clocks per sample period (27 MHz / 8 kHz); must be >= 4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a segment; honoured only in IDLE
- stop  input  1  abort playback; honoured in any state
- seg_base  input  ADDR  first ROM address of the segment; latched on an accepted start
- seg_len  input  ADDR  number of samples; latched on an accepted start
- busy  output  1  high from the cycle after an accepted start until done or stop
- done  output  1  one-cycle pulse when a segment completes normally
- rom_addr  output  ADDR  registered address to the ROM (ROM read latency is 1 clk)
- rom_data  input  WIDTH  signed ROM read data
- sample  output  WIDTH  signed current sample, registered
- sample_valid  output  1  one-cycle pulse when sample updates from the ROM
- pwm_out  output  1  registered PWM audio output

Behaviour:
- Reset values: busy=0, done=0, rom_addr=0, sample=0, sample_valid=0, pwm_out=0. State is IDLE; all counters are 0.
- States: IDLE, FETCH, CAPTURE, WAIT.
- IDLE, start=1, stop=0, seg_len!=0:
  - latch base and len; rom_addr<=base; period counter<=0; index<=0.
  - go to FETCH; busy=1 from the next cycle.
- IDLE, start=1, seg_len==0: done pulses the next cycle; stay IDLE; busy stays 0.
- IDLE, start and stop high together: stop wins; no action.
- FETCH (1 cycle): rom_addr is stable, ROM registers data. Go to CAPTURE.
- CAPTURE (1 cycle): sample<=rom_data; sample_valid=1 the following cycle. Go to WAIT.
- WAIT: the period counter counts cycles since the current fetch started. When it reaches DIV-1:
  - If index==len-1: pulse done, clear busy and return sample to 0, all effective in the same next cycle; go IDLE.
  - Else: rom_addr<=rom_addr+1 (mod 2^ADDR wrap), index+1, counter<=0; go FETCH.
- Timing:
  - Fetch k starts DIV*k cycles after the first FETCH cycle.
  - sample_valid for fetch k is asserted exactly 2 cycles after its FETCH cycle.
  - done is asserted len*DIV cycles after the first FETCH cycle.
- start while busy: ignored; latched base/len are unaffected.
- stop in any non-IDLE state: next cycle is IDLE, busy=0, sample=0, no done pulse, no further sample_valid. An in-flight capture is discarded.
- rom_data is sampled only in CAPTURE; its value in other cycles is don't-care.
- PWM:
  - Free-running WIDTH-bit counter, reset 0, increments every clk.
  - level = sample with MSB inverted (offset binary).
  - pwm_out <= (counter < level). Sample 0 gives a 50% duty cycle; the most negative sample gives constant 0.
- Reset mid-playback: everything returns to reset values the next cycle; no done pulse.

Optional Feature:
- Macro: SAMPLE_PLAYER_LOOP_EN.
- Defined: adds input port loop (1 bit). At the end of the last period (index==len-1, counter==DIV-1) with loop=1:
  - rom_addr<=base, index<=0, go to FETCH.
  - no done pulse; busy stays 1; no gap cycle, so period spacing is preserved.
  - loop is sampled only at that boundary; stop still aborts.
- Undefined: no loop port; every segment is one-shot as described above.

Test Plan:
- DIV=8, base=0x0010, len=3, ROM[0x10..0x12]=0x05,0x80,0x7F:
  - rom_addr=0x10/0x11/0x12 at FETCH cycles 0/8/16.
  - sample_valid at cycles 2/10/18 with sample=5,-128,127.
  - done at cycle 24; busy low from 24; sample=0 after.
- seg_len=0 start -> done pulse next cycle, busy never high, no sample_valid.
- base=0xFFFE, len=4 -> rom_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001.
- stop asserted in cycle 9 of a 5-sample segment -> IDLE at cycle 10, sample=0, no done, no further sample_valid. A start in cycle 5 during playback is ignored.
- PWM: hold sample=0 for 512 clks -> pwm_out high 128 of every 256. Sample=-128 -> pwm_out constantly 0. Sample=127 -> high 255 of every 256.
- With SAMPLE_PLAYER_LOOP_EN defined, loop=1, len=2, DIV=8 -> fetches at 0,8,16,24 with addresses base,base+1,base,base+1. No done until loop=0, then done at the next segment end.
